acc_adder_param: RTL and testbench
==================================

Name: acc_adder_param

Overview:
- Parametrised successor of the team's fixed 13-bit unsigned/signed adders.
- Accumulates a frame of TAPS consecutive accepted samples into a wide internal accumulator, then presents one result at OUT_W bits.
- Each frame runs in either signed or unsigned mode.
- Sits after the FIR coefficient-multiply stage as the tap-summing stage, using valid/ready handshakes on input and output.

Parameters:
- DATA_W, 13: input sample width.
- TAPS, 4: samples per frame; legal range ≥2.
- OUT_W, 13: result width; legal range OUT_W ≤ ACC_W.
- ACC_W, DATA_W+$clog2(TAPS)+1: internal signed accumulator width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  sample.
- in_signed  input  1  1 = two's-complement sample (sign-extend), 0 = unsigned (zero-extend).
- in_valid  input  1  sample offered.
- in_ready  output  1  block can accept a sample.
- out_sum  output  OUT_W  frame result.
- out_ovf  output  1  frame sum is outside the OUT_W range for the frame's mode.
- out_valid  output  1  result held.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=ACC, acc=0, count=0, out_sum=0, out_ovf=0, out_valid=0, in_ready=1. The frame mode latch is cleared to signed.
- Reset mid-frame discards any partial sum. Reset while in HOLD drops the pending result.
- State ACC:
  - in_ready=1 and out_valid=0.
  - A transfer occurs on a clk edge where in_valid && in_ready.
  - Each transfer extends in_data to ACC_W per mode and adds it to acc. Then count++.
  - On the first transfer of a frame (count==0), in_signed is latched as the frame mode. in_signed on later transfers of the same frame is ignored.
  - On the transfer that makes count==TAPS, the following happen and the state moves to HOLD:
    - the full sum is computed;
    - out_sum and out_ovf are registered;
    - out_valid=1 from the next cycle.
  - Latency: 1 cycle from the last sample's transfer edge to out_valid high.
- State HOLD:
  - in_ready=0 and out_valid=1.
  - out_sum and out_ovf remain stable until handshake.
  - in_valid is ignored; no sample is consumed.
  - On out_valid && out_ready: out_valid=0, acc=0, count=0, state goes to ACC.
  - The first new sample is accepted the cycle after the handshake. Throughput is TAPS+1 cycles per frame with no backpressure.
- Range check against OUT_W:
  - Signed mode: range is -2^(OUT_W-1) .. 2^(OUT_W-1)-1.
  - Unsigned mode: range is 0 .. 2^OUT_W-1.
  - out_ovf=1 when the full ACC_W sum is outside the range.
- Default out_sum = low OUT_W bits of the sum, i.e. wrap-around, as in the existing adders.
- ACC_W is sized so the internal accumulator never overflows for TAPS samples.
- in_valid held high continuously means back-to-back transfers in ACC, one per cycle.

Optional Feature:
- Macro: ACC_ADDER_SATURATE_EN.
- Defined: when out_ovf=1, out_sum clamps to the nearest range bound for the frame's mode (signed max/min, unsigned max or 0). out_ovf still asserts.
- Undefined: out_sum wraps (low OUT_W bits); out_ovf still asserts. No clamp logic is present.

Decomposition:
- Package acc_adder_pkg:
  - state typedef {ACC, HOLD};
  - mode typedef {MODE_UNSIGNED, MODE_SIGNED};
  - localparam helper for ACC_W;
  - functions returning signed/unsigned min/max for a given width.
- One sub-module, acc_adder_ext: combinational sign/zero extension DATA_W to ACC_W selected by mode. It is reused by later FIR stages.
- Range check and clamp stay in the top module.

Test Plan:
- Reset: assert rst 2 cycles mid-operation → out_valid=0, in_ready=1, out_sum=0, out_ovf=0 on the cycle after release.
- Signed frame (defaults): samples 0x0001, 0x1FFF, 0x0005, 0x0007 with in_signed=1 → out_sum=12, out_ovf=0; out_valid rises 1 cycle after the 4th transfer.
- Unsigned frame, same samples with in_signed=0 → sum 8204, out_ovf=1.
  - Without the macro: out_sum=12.
  - With ACC_ADDER_SATURATE_EN: out_sum=0x1FFF.
- Signed overflow: four samples of 0x0FFF (4095) signed → out_ovf=1.
  - Without the macro: out_sum=0x1FFC (−4).
  - With the macro: out_sum=0x0FFF.
- Backpressure and mode latch:
  - First frame: in_signed=1 on the first sample, toggled to 0 for the rest; samples 0x1FFF ×4 → out_sum=−4 (signed).
  - Hold out_ready=0 for 5 cycles with in_valid=1 → out_sum stable, in_ready=0, no extra sample counted.
  - Then out_ready=1; the next frame of 1,1,1,1 → out_sum=4.
- Reset mid-frame: 2 samples of 100 accepted, then rst 1 cycle, then 4 samples of 1 → out_sum=4, out_ovf=0.

Source files
------------

// File: rtl/acc_adder_pkg.sv
// Shared types and range helpers for the tap-summing accumulator.
// Range helpers return 64-bit signed bounds so callers can compare against any ACC_W < 64.
package acc_adder_pkg;

  typedef enum logic {ACC, HOLD} state_e;
  typedef enum logic {MODE_UNSIGNED, MODE_SIGNED} mode_e;

  localparam int unsigned BOUND_W = 64;

  // Accumulator must hold TAPS full-scale samples in either mode without overflow.
  function automatic int unsigned acc_width(int unsigned data_w, int unsigned taps);
    return data_w + $clog2(taps) + 1;
  endfunction

  function automatic logic signed [BOUND_W-1:0] smax(int unsigned w);
    logic [BOUND_W-1:0] one;
    one = 64'd1;
    return $signed((one << (w - 1)) - 64'd1);
  endfunction

  function automatic logic signed [BOUND_W-1:0] smin(int unsigned w);
    logic [BOUND_W-1:0] one;
    one = 64'd1;
    return $signed(~((one << (w - 1)) - 64'd1));
  endfunction

  function automatic logic signed [BOUND_W-1:0] umax(int unsigned w);
    logic [BOUND_W-1:0] one;
    one = 64'd1;
    return $signed((one << w) - 64'd1);
  endfunction

  function automatic logic signed [BOUND_W-1:0] umin(int unsigned w);
    return (w == 0) ? 64'sd0 : 64'sd0;
  endfunction

endpackage

// File: rtl/acc_adder_ext.sv
// Combinational sign/zero extension of a DATA_W sample to ACC_W, selected by frame mode.
module acc_adder_ext
  import acc_adder_pkg::*;
#(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned ACC_W  = 16
) (
  input  logic [DATA_W-1:0] din,
  input  mode_e             mode,
  output logic [ACC_W-1:0]  dout
);

  logic fill;

  assign fill = (mode == MODE_SIGNED) ? din[DATA_W-1] : 1'b0;
  assign dout = {{(ACC_W - DATA_W){fill}}, din};

endmodule

// File: rtl/acc_adder_param.sv
// Frame accumulator: sums TAPS accepted samples, presents one OUT_W result with overflow flag.
// Build option ACC_ADDER_SATURATE_EN clamps out-of-range results instead of wrapping.
module acc_adder_param
  import acc_adder_pkg::*;
#(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned TAPS   = 4,
  parameter int unsigned OUT_W  = 13,
  parameter int unsigned ACC_W  = acc_width(DATA_W, TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_signed,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = $clog2(TAPS + 1);
  localparam logic signed [BOUND_W-1:0] S_MAX = smax(OUT_W);
  localparam logic signed [BOUND_W-1:0] S_MIN = smin(OUT_W);
  localparam logic signed [BOUND_W-1:0] U_MAX = umax(OUT_W);
  localparam logic signed [BOUND_W-1:0] U_MIN = umin(OUT_W);

  state_e                    state_q;
  mode_e                     mode_q;
  mode_e                     frame_mode;
  logic signed [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]          count_q;
  logic [ACC_W-1:0]          ext_data;
  logic signed [ACC_W-1:0]   sum_next;
  logic signed [BOUND_W-1:0] sum_wide;
  logic [OUT_W-1:0]          res;
  logic                      ovf;
  logic                      take;
  logic                      last;

  // The first sample of a frame sets the mode; later samples reuse the latched one.
  assign frame_mode = (count_q == '0) ? (in_signed ? MODE_SIGNED : MODE_UNSIGNED) : mode_q;

  acc_adder_ext #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_ext (
    .din  (in_data),
    .mode (frame_mode),
    .dout (ext_data)
  );

  assign sum_next = acc_q + $signed(ext_data);
  assign sum_wide = {{(BOUND_W - ACC_W){sum_next[ACC_W-1]}}, sum_next};
  assign in_ready = (state_q == ACC);
  assign take     = in_valid && in_ready;
  assign last     = (count_q == CNT_W'(TAPS - 1));

  always_comb begin
    ovf = 1'b0;
    res = sum_next[OUT_W-1:0];
    if (frame_mode == MODE_SIGNED) begin
      if (sum_wide > S_MAX) begin
        ovf = 1'b1;
`ifdef ACC_ADDER_SATURATE_EN
        res = S_MAX[OUT_W-1:0];
`endif
      end else if (sum_wide < S_MIN) begin
        ovf = 1'b1;
`ifdef ACC_ADDER_SATURATE_EN
        res = S_MIN[OUT_W-1:0];
`endif
      end
    end else begin
      if (sum_wide > U_MAX) begin
        ovf = 1'b1;
`ifdef ACC_ADDER_SATURATE_EN
        res = U_MAX[OUT_W-1:0];
`endif
      end else if (sum_wide < U_MIN) begin
        ovf = 1'b1;
`ifdef ACC_ADDER_SATURATE_EN
        res = U_MIN[OUT_W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      mode_q    <= MODE_SIGNED;
      acc_q     <= '0;
      count_q   <= '0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (take) begin
            acc_q   <= sum_next;
            count_q <= count_q + CNT_W'(1);
            mode_q  <= frame_mode;
            if (last) begin
              state_q   <= HOLD;
              out_sum   <= res;
              out_ovf   <= ovf;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q   <= ACC;
            acc_q     <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_adder_param.sv
// Directed bench for acc_adder_param at default parameters (DATA_W=13, TAPS=4, OUT_W=13).
module tb_acc_adder_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] in_data;
  logic        in_signed;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] out_sum;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

`ifdef ACC_ADDER_SATURATE_EN
  localparam logic [12:0] EXP_UNS  = 13'h1FFF;
  localparam logic [12:0] EXP_SOVF = 13'h0FFF;
`else
  localparam logic [12:0] EXP_UNS  = 13'd12;
  localparam logic [12:0] EXP_SOVF = 13'h1FFC;
`endif

  always #5 clk = ~clk;

  acc_adder_param dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_signed (in_signed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic push(input logic [12:0] d, input logic s);
    in_data   = d;
    in_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic handshake();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst0_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst0_ready: got %b want 1", in_ready); end
    checks++; if (out_sum !== 13'd0) begin errors++; $display("FAIL rst0_sum: got %h want 0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rst0_ovf: got %b want 0", out_ovf); end
    // Park a result in HOLD, then reset over it.
    for (int i = 0; i < 4; i++) push(13'd1, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_sum !== 13'd4) begin errors++; $display("FAIL rst_pre_sum: got %h want 4", out_sum); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    checks++; if (out_sum !== 13'd0) begin errors++; $display("FAIL rst_sum: got %h want 0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", out_ovf); end
  endtask

  task automatic test_signed_frame();
    push(13'h0001, 1'b1);
    push(13'h1FFF, 1'b1);
    push(13'h0005, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sgn_early_valid: got %b want 0", out_valid); end
    push(13'h0007, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sgn_latency: got %b want 1", out_valid); end
    checks++; if (out_sum !== 13'd12) begin errors++; $display("FAIL sgn_sum: got %h want c", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL sgn_ovf: got %b want 0", out_ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sgn_hold_ready: got %b want 0", in_ready); end
    handshake();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sgn_hs_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sgn_hs_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_unsigned_frame();
    push(13'h0001, 1'b0);
    push(13'h1FFF, 1'b0);
    push(13'h0005, 1'b0);
    push(13'h0007, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL uns_valid: got %b want 1", out_valid); end
    checks++; if (out_sum !== EXP_UNS) begin errors++; $display("FAIL uns_sum: got %h want %h", out_sum, EXP_UNS); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL uns_ovf: got %b want 1", out_ovf); end
    handshake();
  endtask

  task automatic test_signed_overflow();
    for (int i = 0; i < 4; i++) push(13'h0FFF, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sovf_valid: got %b want 1", out_valid); end
    checks++; if (out_sum !== EXP_SOVF) begin errors++; $display("FAIL sovf_sum: got %h want %h", out_sum, EXP_SOVF); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL sovf_ovf: got %b want 1", out_ovf); end
    handshake();
  endtask

  task automatic test_backpressure();
    push(13'h1FFF, 1'b1);
    for (int i = 0; i < 3; i++) push(13'h1FFF, 1'b0);
    // Unsigned reading would give 32764 with ovf=1; the latched signed mode gives -4, no ovf.
    checks++; if (out_sum !== 13'h1FFC) begin errors++; $display("FAIL bp_sum: got %h want 1ffc", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf: got %b want 0", out_ovf); end
    in_data  = 13'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_sum !== 13'h1FFC) begin errors++; $display("FAIL bp_hold_sum[%0d]: got %h want 1ffc", i, out_sum); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
    end
    handshake();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_hs_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 4; i++) push(13'd1, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
    checks++; if (out_sum !== 13'd4) begin errors++; $display("FAIL bp_next_sum: got %h want 4", out_sum); end
    handshake();
  endtask

  task automatic test_reset_midframe();
    push(13'd100, 1'b1);
    push(13'd100, 1'b1);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid0: got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) push(13'd1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_early_valid: got %b want 0", out_valid); end
    push(13'd1, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b want 1", out_valid); end
    checks++; if (out_sum !== 13'd4) begin errors++; $display("FAIL mid_sum: got %h want 4", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b want 0", out_ovf); end
    handshake();
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_signed = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_signed_frame();
    test_unsigned_frame();
    test_signed_overflow();
    test_backpressure();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
